// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: byte-memory req/ack, instruction valid/ready and redirect.
// The fetch unit uses the master modport; memory/consumer side uses slave.
interface instr_fetch_unit_if #(
    parameter int unsigned AW = 8
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [7:0]    mem_rdata;
    logic [31:0]   instr;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic          redirect_en;
    logic [AW-1:0] redirect_pc;
    logic          fetch_fault;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata,
        output instr, op, funct, instr_pc, instr_valid,
        input  instr_ready,
        input  redirect_en, redirect_pc,
        output fetch_fault
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata,
        input  instr, op, funct, instr_pc, instr_valid,
        output instr_ready,
        output redirect_en, redirect_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage of the 8-bit multicycle MIPS: assembles four big-endian bytes into one instruction.
// Define FETCH_TIMEOUT_EN to build the WAIT watchdog and the sticky FAULT state.
module instr_fetch_unit #(
    parameter int unsigned    AW       = 8,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int unsigned    TIMEOUT  = 15
) (
    input  logic                clk_i,
    input  logic                reset_i,
    instr_fetch_unit_if.master  bus
);

    if (TIMEOUT == 0) begin : g_timeout_chk
        $error("instr_fetch_unit: TIMEOUT must be nonzero");
    end

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
`ifdef FETCH_TIMEOUT_EN
        S_VALID,
        S_FAULT
`else
        S_VALID
`endif
    } state_e;

    state_e        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] tgt_q;
    logic [1:0]    byte_cnt_q;
    logic          drop_q;
    logic          mem_req_q;
    logic [AW-1:0] mem_addr_q;
    logic [31:0]   instr_q;
    logic [AW-1:0] instr_pc_q;
    logic          instr_valid_q;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] tmo_q;
    logic          fault_q;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_ISSUE;
            pc_q          <= RESET_PC;
            tgt_q         <= '0;
            byte_cnt_q    <= '0;
            drop_q        <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_ISSUE: begin
                    if (bus.redirect_en) begin
                        pc_q          <= bus.redirect_pc;
                        byte_cnt_q    <= '0;
                        instr_valid_q <= 1'b0;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= pc_q;
                        if (byte_cnt_q == 2'd0) begin
                            instr_pc_q <= pc_q;
                        end
`ifdef FETCH_TIMEOUT_EN
                        tmo_q      <= '0;
`endif
                        state_q    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (bus.mem_ack) begin
                        mem_req_q <= 1'b0;
                        // A redirect seen now or earlier in this WAIT discards the returning byte.
                        if (drop_q || bus.redirect_en) begin
                            pc_q       <= bus.redirect_en ? bus.redirect_pc : tgt_q;
                            byte_cnt_q <= '0;
                            drop_q     <= 1'b0;
                            state_q    <= S_ISSUE;
                        end else begin
                            case (byte_cnt_q)
                                2'd0:    instr_q[31:24] <= bus.mem_rdata;
                                2'd1:    instr_q[23:16] <= bus.mem_rdata;
                                2'd2:    instr_q[15:8]  <= bus.mem_rdata;
                                default: instr_q[7:0]   <= bus.mem_rdata;
                            endcase
                            pc_q       <= pc_q + 1'b1;
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd3) begin
                                instr_valid_q <= 1'b1;
                                state_q       <= S_VALID;
                            end else begin
                                state_q       <= S_ISSUE;
                            end
                        end
                    end else begin
                        if (bus.redirect_en) begin
                            drop_q <= 1'b1;
                            tgt_q  <= bus.redirect_pc;
                        end
`ifdef FETCH_TIMEOUT_EN
                        if (tmo_q == TW'(TIMEOUT - 1)) begin
                            mem_req_q <= 1'b0;
                            fault_q   <= 1'b1;
                            state_q   <= S_FAULT;
                        end else begin
                            tmo_q     <= tmo_q + 1'b1;
                        end
`endif
                    end
                end

                S_VALID: begin
                    if (bus.redirect_en) begin
                        pc_q          <= bus.redirect_pc;
                        byte_cnt_q    <= '0;
                        instr_valid_q <= 1'b0;
                        state_q       <= S_ISSUE;
                    end else if (bus.instr_ready) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_ISSUE;
                    end
                end

`ifdef FETCH_TIMEOUT_EN
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
`endif

                default: begin
                    state_q <= S_ISSUE;
                end
            endcase
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.instr       = instr_q;
    assign bus.op          = instr_q[31:26];
    assign bus.funct       = instr_q[5:0];
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
    assign bus.fetch_fault = fault_q;
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: transaction-level byte-queue model compared
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch_unit;

    localparam int unsigned TIMEOUT = 15;
    localparam logic [7:0]  RST_PC  = 8'hFE;

    logic clk;
    logic rst;

    instr_fetch_unit_if #(.AW(8)) bus ();

    instr_fetch_unit #(
        .AW       (8),
        .RESET_PC (RST_PC),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- memory responder ----------------
    logic [7:0] mem [256];
    int  lat_fixed = 0;     // <0 selects random latency 0..4 per request
    bit  ack_en    = 1'b1;
    bit  spurious  = 1'b0;

    initial begin
        bit busy;
        int wcnt, cur_lat;
        busy = 1'b0; wcnt = 0; cur_lat = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) begin
                if (!busy) begin
                    busy    = 1'b1;
                    wcnt    = 0;
                    cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 4));
                end
                if (ack_en && wcnt >= cur_lat) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    busy          = 1'b0;
                end else begin
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = 8'($urandom);
                    wcnt++;
                end
            end else begin
                busy          = 1'b0;
                bus.mem_ack   = spurious && ($urandom_range(0, 7) == 0);
                bus.mem_rdata = 8'($urandom);
            end
        end
    end

    // ---------------- behavioural model ----------------
    localparam int PH_ISSUE = 0, PH_WAIT = 1, PH_VALID = 2, PH_FAULT = 3;

    logic [7:0]  m_pc, m_tgt;
    logic [7:0]  got [$];
    int          m_ph, m_wn;
    bit          m_drop;
    logic        e_req, e_valid, e_fault;
    logic [7:0]  e_addr, e_ipc;
    logic [31:0] e_word;

    always @(posedge clk) begin
        if (rst) begin
            m_pc = RST_PC; m_tgt = 8'h00; got.delete(); m_ph = PH_ISSUE; m_wn = 0; m_drop = 0;
            e_req = 0; e_valid = 0; e_fault = 0; e_addr = 8'h00; e_ipc = 8'h00; e_word = 32'h0;
        end else begin
            case (m_ph)
                PH_ISSUE: begin
                    if (bus.redirect_en) begin
                        m_pc = bus.redirect_pc;
                        got.delete();
                    end else begin
                        e_req = 1; e_addr = m_pc;
                        if (got.size() == 0) e_ipc = m_pc;
                        m_wn = 0; m_ph = PH_WAIT;
                    end
                end
                PH_WAIT: begin
                    if (bus.mem_ack) begin
                        e_req = 0;
                        if (bus.redirect_en || m_drop) begin
                            m_pc   = bus.redirect_en ? bus.redirect_pc : m_tgt;
                            m_drop = 0;
                            got.delete();
                            m_ph   = PH_ISSUE;
                        end else begin
                            got.push_back(bus.mem_rdata);
                            m_pc = m_pc + 8'd1;
                            if (got.size() == 4) begin
                                e_word  = {got[0], got[1], got[2], got[3]};
                                e_valid = 1;
                                m_ph    = PH_VALID;
                            end else begin
                                m_ph = PH_ISSUE;
                            end
                        end
                    end else begin
                        if (bus.redirect_en) begin m_drop = 1; m_tgt = bus.redirect_pc; end
                        m_wn++;
`ifdef FETCH_TIMEOUT_EN
                        if (m_wn == TIMEOUT) begin e_req = 0; e_fault = 1; m_ph = PH_FAULT; end
`endif
                    end
                end
                PH_VALID: begin
                    if (bus.redirect_en || bus.instr_ready) begin
                        if (bus.redirect_en) m_pc = bus.redirect_pc;
                        got.delete();
                        e_valid = 0;
                        m_ph    = PH_ISSUE;
                    end
                end
                default: ;
            endcase
        end
    end

    // every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        check("mem_req", bus.mem_req, e_req);
        check("instr_valid", bus.instr_valid, e_valid);
        check("fetch_fault", bus.fetch_fault, e_fault);
        if (e_req) check("mem_addr", bus.mem_addr, e_addr);
        if (e_valid) begin
            check("instr", bus.instr, e_word);
            check("instr_pc", bus.instr_pc, e_ipc);
            check("op", bus.op, e_word[31:26]);
            check("funct", bus.funct, e_word[5:0]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (bus.instr_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (bus.instr_valid !== 1'b1) check("valid_timeout", bus.instr_valid, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] addrs [$];
        int n_instr;
        logic prev_v;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[8'h00] = 8'h8C; mem[8'h01] = 8'h41; mem[8'h02] = 8'h00; mem[8'h03] = 8'h05;
        mem[8'h04] = 8'h27; mem[8'h05] = 8'hBD; mem[8'h06] = 8'hFF; mem[8'h07] = 8'hF8;
        mem[8'h40] = 8'hDE; mem[8'h41] = 8'hAD; mem[8'h42] = 8'hBE; mem[8'h43] = 8'hEF;
        mem[8'hFE] = 8'h12; mem[8'hFF] = 8'h34;

        rst = 1'b1;
        bus.instr_ready = 1'b1;
        bus.redirect_en = 1'b0;
        bus.redirect_pc = 8'h00;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_valid", bus.instr_valid, 0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_instr_pc", bus.instr_pc, 0);
        check("rst_fault", bus.fetch_fault, 0);
        rst = 1'b0;

        // zero-wait fetch from RESET_PC straddling the wrap
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1) addrs.push_back(bus.mem_addr);
            if (i == 7) check("valid_not_early", bus.instr_valid, 0);
        end
        check("first_latency_valid", bus.instr_valid, 1);
        check("addr_count", addrs.size(), 4);
        if (addrs.size() == 4) begin
            check("addr0", addrs[0], 8'hFE);
            check("addr1", addrs[1], 8'hFF);
            check("addr2", addrs[2], 8'h00);
            check("addr3", addrs[3], 8'h01);
        end
        check("wrap_instr", bus.instr, 32'h12348C41);
        check("wrap_instr_pc", bus.instr_pc, 8'hFE);

        @(negedge clk);
        wait_valid(40, n);
        check("throughput", n + 1, 9);
        check("second_instr_pc", bus.instr_pc, 8'h02);
        check("second_instr", bus.instr, 32'h000527BD);

        // redirect together with acceptance
        bus.redirect_en = 1'b1; bus.redirect_pc = 8'h00;
        @(negedge clk);
        bus.redirect_en = 1'b0;
        wait_valid(40, n);
        check("redir_latency", n, 8);
        check("instr_8c", bus.instr, 32'h8C410005);
        check("op_8c", bus.op, 6'b100011);
        check("funct_8c", bus.funct, 6'b000101);
        check("instr_pc_0", bus.instr_pc, 8'h00);

        // three wait states per byte, consumer stalls 5 cycles
        lat_fixed = 3;
        @(negedge clk);
        wait_valid(100, n);
        check("wait3_latency", n, 20);
        check("wait3_instr_pc", bus.instr_pc, 8'h04);
        bus.instr_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("hold_instr", bus.instr, 32'h27BDFFF8);
            check("hold_valid", bus.instr_valid, 1);
            check("hold_no_req", bus.mem_req, 0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("accept_valid_low", bus.instr_valid, 0);
        check("accept_req_low", bus.mem_req, 0);
        @(negedge clk);
        check("next_req", bus.mem_req, 1);
        check("next_addr", bus.mem_addr, 8'h08);

        // redirect while waiting on byte 2 of the instruction at 8
        n = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr === 8'h0A) && n < 100) begin
            @(negedge clk); n++;
        end
        check("reach_addr_0A", bus.mem_addr, 8'h0A);
        bus.redirect_en = 1'b1; bus.redirect_pc = 8'h40;
        @(negedge clk);
        bus.redirect_en = 1'b0;
        n = 0;
        while (!(bus.mem_req === 1'b1 && bus.mem_addr !== 8'h0A) && n < 100) begin
            @(negedge clk); n++;
        end
        check("restart_addr", bus.mem_addr, 8'h40);
        check("no_partial_valid", bus.instr_valid, 0);
        wait_valid(100, n);
        check("redir_instr_pc", bus.instr_pc, 8'h40);
        check("redir_instr", bus.instr, 32'hDEADBEEF);

        // reset mid-handshake
        @(negedge clk);
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        check("midrst_req", bus.mem_req, 0);
        check("midrst_valid", bus.instr_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_req", bus.mem_req, 1);
        check("postrst_addr", bus.mem_addr, RST_PC);

        // memory never answers
        ack_en = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (i == 14) check("tmo_not_early", bus.fetch_fault, 0);
        end
        check("tmo_fault", bus.fetch_fault, 1);
        check("tmo_req", bus.mem_req, 0);
        ack_en = 1'b1;
        bus.redirect_en = 1'b1; bus.redirect_pc = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("fault_sticky", bus.fetch_fault, 1);
            check("fault_no_valid", bus.instr_valid, 0);
        end
        bus.redirect_en = 1'b0;
`else
        repeat (20) @(negedge clk);
        check("noack_req_held", bus.mem_req, 1);
        check("noack_no_fault", bus.fetch_fault, 0);
        ack_en = 1'b1;
`endif
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        lat_fixed = -1;
        spurious  = 1'b1;
        n_instr   = 0;
        prev_v    = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.instr_valid === 1'b1 && !prev_v) n_instr++;
            prev_v = (bus.instr_valid === 1'b1);
            bus.instr_ready = ($urandom_range(0, 3) != 0);
            bus.redirect_en = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255))
                                                           : 8'($urandom);
            rst = ($urandom_range(0, 499) == 0);
        end
        check("random_progress", (n_instr >= 10), 1);

        rst = 1'b0;
        bus.redirect_en = 1'b0;
        spurious = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage for the 8-bit multicycle MIPS core.
- Reads four consecutive bytes from byte-wide instruction memory over a req/ack handshake and assembles a 32-bit big-endian instruction.
- Presents op/funct and the full instruction to the multicycle controller/datapath with a valid/ready handshake.
- Accepts PC redirects (branch/jump targets) from the datapath.

Parameters:
- AW, 8, memory/PC address width.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, max WAIT cycles before fault (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  byte read request; held until mem_ack.
- mem_addr  out  AW  byte address; stable while mem_req=1.
- mem_ack  in  1  one-cycle pulse; mem_rdata valid this cycle.
- mem_rdata  in  8  read byte.
- instr  out  32  assembled instruction; first fetched byte is instr[31:24].
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- instr_pc  out  AW  address of the first byte of the held instruction.
- instr_valid  out  1  instr/op/funct/instr_pc are valid.
- instr_ready  in  1  consumer accepts the instruction.
- redirect_en  in  1  load new fetch PC.
- redirect_pc  in  AW  redirect target.
- fetch_fault  out  1  sticky timeout fault; tied 0 when the optional feature is compiled out.

Behaviour:
- Reset values: pc=RESET_PC, byte_cnt=0, state=ISSUE, mem_req=0, mem_addr=0, instr=0, instr_pc=0, instr_valid=0, fetch_fault=0, drop=0.
- Reset applies mid-handshake: an outstanding request is abandoned and memory must tolerate req deassertion.
- States: ISSUE, WAIT, VALID, FAULT (FAULT only with the optional feature). All outputs are registered.
- ISSUE (one cycle):
  - mem_req<=1, mem_addr<=pc.
  - If byte_cnt==0, instr_pc<=pc.
  - Next state WAIT.
- WAIT:
  - mem_ack may arrive in any WAIT cycle, including the first.
  - On ack with drop=0: write mem_rdata into byte slot byte_cnt (slot 0 goes to [31:24]), pc<=pc+1 mod 2^AW, mem_req<=0.
  - If byte_cnt==3: byte_cnt<=0, next state VALID. Otherwise byte_cnt++, next state ISSUE.
- VALID:
  - instr_valid=1; outputs are held stable until accepted.
  - instr_ready=1 → instr_valid<=0, next state ISSUE. pc already points to the next instruction.
- Zero-wait memory: 2 cycles per byte; 8 cycles from the first ISSUE cycle to instr_valid high. Throughput is 1 instruction per 9 cycles with instr_ready tied high.
- Redirect in ISSUE or VALID: pc<=redirect_pc, byte_cnt<=0, instr_valid<=0, next state ISSUE. A redirect in the same cycle as instr_ready counts as acceptance plus redirect.
- Redirect in WAIT:
  - The request stays outstanding; drop<=1 and the target is latched (last redirect wins).
  - On ack: the byte is discarded, pc<=latched target, byte_cnt<=0, drop<=0, next state ISSUE.
  - Redirect in the same cycle as ack: that ack's byte is dropped and the fetch restarts at redirect_pc.
- PC wrap: pc=2^AW-1 increments to 0. An instruction may straddle the wrap.
- mem_ack outside WAIT is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter is cleared on entry to WAIT and increments each WAIT cycle without mem_ack.
  - At TIMEOUT cycles: mem_req<=0, fetch_fault<=1 (sticky), state FAULT.
  - FAULT ignores all inputs except reset; instr_valid stays 0.
- Not defined: no counter and no FAULT state; WAIT lasts indefinitely; fetch_fault is constant 0.

Test Plan:
- Zero-wait memory holding 8C 41 00 05 at 0..3, instr_ready=1 → instr=32'h8C410005, op=6'b100011, funct=6'b000101, instr_pc=0, instr_valid high 8 cycles after the first ISSUE; second instr_pc=4.
- Memory with 3 wait states per byte, instr_ready held 0 for 5 cycles after valid → instr stable; mem_req stays 0 during VALID; next fetch starts at pc=4 one cycle after ready.
- Redirect to 8'h40 while WAIT on byte 2 (addr 6) → ack byte discarded, next mem_addr=8'h40, instr_pc=8'h40, no partial instruction emitted.
- RESET_PC=8'hFE, sequential fetch → mem_addr sequence FE, FF, 00, 01; instr_pc=FE; next instr_pc=02.
- Reset asserted during WAIT with mem_req=1 → next cycle mem_req=0, instr_valid=0, then ISSUE at RESET_PC.
- With FETCH_TIMEOUT_EN and TIMEOUT=15, mem_ack never asserted → fetch_fault=1 after 15 WAIT cycles, mem_req=0, remains so until reset; without the macro, mem_req stays 1 and fetch_fault stays 0.
